instr_prefetch_buffer: RTL and testbench
========================================

Name: instr_prefetch_buffer

Overview:
- Upstream neighbour of the instruction fetch stage.
- Holds two 64B instruction lines (16 × 32-bit words each) fetched from local store (LS). Serves even-aligned instruction pairs to IF on request.
- Prefetches the next sequential line while IF consumes the second half of the current line.
- Handles branch/stall redirects and code-invalidation from LS writes.

Parameters:
- LINE_WORDS, 16, instruction words per line (fixed 64B line).
- PC_W, 8, word-address width of the instruction space (256 words, 16 lines).

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset)
- fetch_req  input  1  IF requests the pair at fetch_pc
- fetch_pc  input  PC_W  word address of the pair; bit 0 ignored (treated as 0)
- redirect  input  1  branch/stall refetch; takes priority over fetch_req
- redirect_pc  input  PC_W  new fetch word address; bit 0 ignored
- inval  input  1  LS code write: clear both line valid bits
- fetch_valid  output  1  fetch_instr0/1 hold the requested pair
- fetch_instr0  output  32  word at the even address
- fetch_instr1  output  32  word at the even address + 1
- ls_req  output  1  line read request to LS
- ls_addr  output  PC_W  line base word address; low 4 bits always 0
- ls_ack  input  1  LS returns a line this cycle; single beat
- ls_data  input  512  line data; word 0 in bits [511:480]

Behaviour:
- Reset (async assert):
  - fetch_valid=0, fetch_instr0/1=0, ls_req=0, ls_addr=0.
  - Both entries invalid, LRU=0, FSM=IDLE, pending-request register cleared.
  - Any ls_ack arriving in IDLE is ignored.
- Storage:
  - Two entries, each holding a 4-bit tag (line index = pc[7:4]), a valid bit and 16 words.
  - A 1-bit LRU points to the victim entry.
- Request capture:
  - Effective request = redirect ? redirect_pc : fetch_pc, valid when (redirect | fetch_req).
  - The request is latched into the pending register.
  - IF holds fetch_req and fetch_pc stable until fetch_valid is seen.
- Hit:
  - Request at cycle t, line resident → fetch_valid=1 at t+1 with words [pc&~1] and [pc|1].
  - LRU is updated to point away from the hit entry.
  - Pairs never straddle lines; pair at word offset 14 returns words 14 and 15.
- Miss:
  - FSM goes IDLE→DEMAND. ls_req=1 from t+1 with ls_addr = {pc[7:4],4'b0}.
  - ls_req is held until ls_ack. On the ack cycle the line is written into the LRU victim, valid is set and ls_req drops.
  - fetch_valid=1 the cycle after ack.
  - Minimum miss latency = 2 cycles beyond LS latency.
- Prefetch:
  - Trigger: FSM=IDLE, a hit served with pc[3] == 1, and line (tag+1) mod 16 not resident.
  - FSM goes to PREFETCH. ls_req asserts the next cycle for the next line; line 15 wraps to line 0.
  - Victim is the entry not holding the current line.
  - On ack the line is installed and FSM returns to IDLE. No fetch_valid is generated by a prefetch.
- Demand miss while in PREFETCH:
  - Same line as the prefetch: convert to DEMAND and keep the same request; fetch_valid the cycle after ack.
  - Different line: wait for the prefetch ack and install it, then issue the demand request the following cycle.
- fetch_valid is a single-cycle pulse per accepted request. A new request may be presented the cycle fetch_valid is high, so back-to-back hits give one pair per cycle.
- Redirect:
  - Cancels any not-yet-delivered fetch_valid; the next cycle's fetch_valid reflects only the redirect target.
  - An outstanding LS transaction cannot be aborted. It completes and its line is installed, then the FSM serves the redirect target (hit or new demand).
- inval:
  - Clears both valid bits the next edge; lines in flight are still installed.
  - A pending hit in the same cycle is suppressed and re-evaluated as a miss.
  - inval and redirect together: invalidate first, then the redirect misses.
- Address wrap: a pc increment from 254 to 0 is handled by IF. The buffer treats pc 0 as line 0 normally.

Test Plan:
- Cold start:
  - Stimulus: release reset, fetch_req pc=0.
  - Response: ls_req=1, ls_addr=0x00. LS acks after 3 cycles with words 0x1000+i. fetch_valid the cycle after ack; instr0=0x1000, instr1=0x1001.
- Sequential stream and prefetch:
  - Stimulus: pc=0,2,…,14 back-to-back.
  - Response: hits one pair/cycle. Prefetch ls_addr=0x10 issued the cycle after the pc=8 hit. pc=16 then hits with no stall.
- Wrap prefetch:
  - Stimulus: line 15 resident, hit at pc=0xF8.
  - Response: prefetch ls_addr=0x00. Next fetch at pc=0 hits.
- Redirect during demand miss:
  - Stimulus: miss at pc=0x40 outstanding, redirect_pc=0x02 (line 0 resident).
  - Response: 0x40 line installed on ack, no fetch_valid for 0x40. fetch_valid next with words 2,3.
- Demand/prefetch collision:
  - Different line: prefetch of 0x20 outstanding, demand pc=0x60 → ack installs 0x20, then ls_addr=0x60 issued the next cycle.
  - Same line: demand pc=0x22 → no second request; fetch_valid the cycle after ack.
- inval and async reset:
  - Stimulus: inval with lines resident, then pc=0.
  - Response: a new ls_req is issued for line 0.
  - Stimulus: reset asserted mid-request.
  - Response: ls_req=0 immediately; a late ls_ack is ignored and valid bits stay 0.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
// Two-entry instruction line buffer feeding IF: serves even-aligned instruction pairs,
// fetches missing lines from local store and prefetches the next sequential line.
module instr_prefetch_buffer #(
    parameter int LINE_WORDS = 16,
    parameter int PC_W       = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [PC_W-1:0]          fetch_pc,
    input  logic                     redirect,
    input  logic [PC_W-1:0]          redirect_pc,
    input  logic                     inval,
    output logic                     fetch_valid,
    output logic [31:0]              fetch_instr0,
    output logic [31:0]              fetch_instr1,
    output logic                     ls_req,
    output logic [PC_W-1:0]          ls_addr,
    input  logic                     ls_ack,
    input  logic [LINE_WORDS*32-1:0] ls_data
);

    localparam int OFF_W     = $clog2(LINE_WORDS);
    localparam int TAG_W     = PC_W - OFF_W;
    localparam int LINE_BITS = LINE_WORDS * 32;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEMAND   = 2'd1,
        ST_PREFETCH = 2'd2,
        ST_PF_WAIT  = 2'd3
    } state_t;

    // Word 0 of a line sits in the most significant 32 bits.
    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [OFF_W-1:0]     idx);
        int base;
        base = (LINE_WORDS - 1 - int'(idx)) * 32;
        line_word = line[base +: 32];
    endfunction

    state_t                 state_r;
    state_t                 state_n;
    logic [TAG_W-1:0]       tag_r [2];
    logic [1:0]             vld_r;
    logic [1:0]             vld_n;
    logic [LINE_BITS-1:0]   line_r [2];
    logic                   lru_r;
    logic                   lru_n;
    logic                   ls_way_r;
    logic                   ls_way_n;
    logic                   pend_valid_r;
    logic                   pend_valid_n;
    logic [PC_W-1:0]        pend_pc_r;
    logic [PC_W-1:0]        pend_pc_n;
    logic                   fetch_valid_r;
    logic                   fetch_valid_n;
    logic [31:0]            instr0_r;
    logic [31:0]            instr0_n;
    logic [31:0]            instr1_r;
    logic [31:0]            instr1_n;
    logic                   ls_req_r;
    logic                   ls_req_n;
    logic [PC_W-1:0]        ls_addr_r;
    logic [PC_W-1:0]        ls_addr_n;

    logic                   req_v_s;
    logic [PC_W-1:0]        req_pc_s;
    logic [TAG_W-1:0]       req_tag_s;
    logic [TAG_W-1:0]       next_tag_s;
    logic [OFF_W-1:0]       even_off_s;
    logic [OFF_W-1:0]       odd_off_s;
    logic                   hit0_s;
    logic                   hit1_s;
    logic                   hit_s;
    logic                   hit_way_s;
    logic                   next_res_s;
    logic                   ack_match_s;
    logic                   install_s;
    logic                   dlv_ent_s;
    logic                   dlv_ls_s;
    logic                   miss_s;
    logic                   pf_s;
    logic                   hold_s;
    logic                   unused_s;

    // An undelivered request (pending) outranks a fresh fetch_req; redirect outranks both.
    always_comb begin
        req_v_s    = redirect | pend_valid_r | fetch_req;
        if (redirect) begin
            req_pc_s = redirect_pc;
        end else if (pend_valid_r) begin
            req_pc_s = pend_pc_r;
        end else begin
            req_pc_s = fetch_pc;
        end
        req_tag_s   = req_pc_s[PC_W-1:OFF_W];
        next_tag_s  = req_tag_s + {{(TAG_W-1){1'b0}}, 1'b1};
        even_off_s  = {req_pc_s[OFF_W-1:1], 1'b0};
        odd_off_s   = {req_pc_s[OFF_W-1:1], 1'b1};
        hit0_s      = vld_r[0] & (tag_r[0] == req_tag_s) & ~inval;
        hit1_s      = vld_r[1] & (tag_r[1] == req_tag_s) & ~inval;
        hit_s       = hit0_s | hit1_s;
        hit_way_s   = hit1_s;
        next_res_s  = (vld_r[0] & (tag_r[0] == next_tag_s)) |
                      (vld_r[1] & (tag_r[1] == next_tag_s));
        ack_match_s = (ls_addr_r[PC_W-1:OFF_W] == req_tag_s);
        install_s   = ls_ack & (state_r != ST_IDLE);
        unused_s    = req_pc_s[0];
    end

    // FSM next state and the action chosen for this cycle's request.
    always_comb begin
        state_n   = state_r;
        dlv_ent_s = 1'b0;
        dlv_ls_s  = 1'b0;
        miss_s    = 1'b0;
        pf_s      = 1'b0;
        hold_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_v_s) begin
                    if (hit_s) begin
                        dlv_ent_s = 1'b1;
                        if (req_pc_s[OFF_W-1] && !next_res_s) begin
                            pf_s    = 1'b1;
                            state_n = ST_PREFETCH;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        miss_s  = 1'b1;
                        state_n = ST_DEMAND;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DEMAND, ST_PREFETCH, ST_PF_WAIT: begin
                if (ls_ack) begin
                    // The in-flight line always lands; then the live request is resolved.
                    if (!req_v_s) begin
                        state_n = ST_IDLE;
                    end else if (ack_match_s) begin
                        dlv_ls_s = 1'b1;
                        state_n  = ST_IDLE;
                    end else if (hit_s) begin
                        dlv_ent_s = 1'b1;
                        state_n   = ST_IDLE;
                    end else begin
                        miss_s  = 1'b1;
                        state_n = ST_DEMAND;
                    end
                end else if (req_v_s) begin
                    if ((state_r == ST_PREFETCH) && hit_s) begin
                        dlv_ent_s = 1'b1;
                    end else if (ack_match_s) begin
                        hold_s  = 1'b1;
                        state_n = ST_DEMAND;
                    end else begin
                        hold_s  = 1'b1;
                        state_n = ST_PF_WAIT;
                    end
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath, LRU, valid bits and LS request.
    always_comb begin
        pend_valid_n  = pend_valid_r;
        pend_pc_n     = pend_pc_r;
        fetch_valid_n = 1'b0;
        instr0_n      = instr0_r;
        instr1_n      = instr1_r;
        ls_req_n      = ls_req_r;
        ls_addr_n     = ls_addr_r;
        ls_way_n      = ls_way_r;
        lru_n         = lru_r;
        vld_n         = inval ? 2'b00 : vld_r;

        // Invalidate is applied before the install so a line in flight survives it.
        if (install_s) begin
            vld_n[ls_way_r] = 1'b1;
            lru_n           = ~ls_way_r;
            ls_req_n        = 1'b0;
        end else begin
            lru_n = lru_r;
        end

        if (req_v_s) begin
            pend_pc_n = req_pc_s;
        end else begin
            pend_pc_n = pend_pc_r;
        end

        if (dlv_ent_s) begin
            fetch_valid_n = 1'b1;
            instr0_n      = line_word(line_r[hit_way_s], even_off_s);
            instr1_n      = line_word(line_r[hit_way_s], odd_off_s);
            lru_n         = ~hit_way_s;
            pend_valid_n  = 1'b0;
        end else if (dlv_ls_s) begin
            fetch_valid_n = 1'b1;
            instr0_n      = line_word(ls_data, even_off_s);
            instr1_n      = line_word(ls_data, odd_off_s);
            pend_valid_n  = 1'b0;
        end else if (miss_s || hold_s) begin
            pend_valid_n = 1'b1;
        end else begin
            pend_valid_n = pend_valid_r;
        end

        if (miss_s) begin
            ls_req_n  = 1'b1;
            ls_addr_n = {req_tag_s, {OFF_W{1'b0}}};
            ls_way_n  = install_s ? ~ls_way_r : lru_r;
        end else if (pf_s) begin
            ls_req_n  = 1'b1;
            ls_addr_n = {next_tag_s, {OFF_W{1'b0}}};
            ls_way_n  = ~hit_way_s;
        end else begin
            ls_way_n = ls_way_r;
        end
    end

    // Control, pending-request and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            lru_r         <= 1'b0;
            ls_way_r      <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_pc_r     <= {PC_W{1'b0}};
            fetch_valid_r <= 1'b0;
            instr0_r      <= 32'h0000_0000;
            instr1_r      <= 32'h0000_0000;
            ls_req_r      <= 1'b0;
            ls_addr_r     <= {PC_W{1'b0}};
        end else begin
            state_r       <= state_n;
            lru_r         <= lru_n;
            ls_way_r      <= ls_way_n;
            pend_valid_r  <= pend_valid_n;
            pend_pc_r     <= pend_pc_n;
            fetch_valid_r <= fetch_valid_n;
            instr0_r      <= instr0_n;
            instr1_r      <= instr1_n;
            ls_req_r      <= ls_req_n;
            ls_addr_r     <= ls_addr_n;
        end
    end

    // Tag and valid state of the two entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_r    <= 2'b00;
            tag_r[0] <= {TAG_W{1'b0}};
            tag_r[1] <= {TAG_W{1'b0}};
        end else begin
            vld_r <= vld_n;
            if (install_s) begin
                tag_r[ls_way_r] <= ls_addr_r[PC_W-1:OFF_W];
            end
        end
    end

    // Line storage; contents are only trusted behind the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (install_s) begin
            line_r[ls_way_r] <= ls_data;
        end
    end

    assign fetch_valid  = fetch_valid_r;
    assign fetch_instr0 = instr0_r;
    assign fetch_instr1 = instr1_r;
    assign ls_req       = ls_req_r;
    assign ls_addr      = ls_addr_r;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: LS content is word(addr) = 0x1000 + addr,
// so every expected pair follows directly from the requested pc.
module tb_instr_prefetch_buffer;

    logic         clk;
    logic         reset;
    logic         fetch_req;
    logic [7:0]   fetch_pc;
    logic         redirect;
    logic [7:0]   redirect_pc;
    logic         inval;
    logic         fetch_valid;
    logic [31:0]  fetch_instr0;
    logic [31:0]  fetch_instr1;
    logic         ls_req;
    logic [7:0]   ls_addr;
    logic         ls_ack;
    logic [511:0] ls_data;

    int n_total = 0;
    int n_bad   = 0;

    instr_prefetch_buffer #(.LINE_WORDS(16), .PC_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_req    (fetch_req),
        .fetch_pc     (fetch_pc),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .inval        (inval),
        .fetch_valid  (fetch_valid),
        .fetch_instr0 (fetch_instr0),
        .fetch_instr1 (fetch_instr1),
        .ls_req       (ls_req),
        .ls_addr      (ls_addr),
        .ls_ack       (ls_ack),
        .ls_data      (ls_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end expected end within 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [7:0] base);
        logic [511:0] d;
        for (int i = 0; i < 16; i++) begin
            d[(15 - i) * 32 +: 32] = 32'h0000_1000 + 32'(base) + 32'(i);
        end
        return d;
    endfunction

    // Advance one clock and drop the single-cycle strobes.
    task automatic cyc();
        @(posedge clk);
        #1;
        ls_ack   = 1'b0;
        redirect = 1'b0;
        inval    = 1'b0;
    endtask

    task automatic req(input logic [7:0] pc);
        fetch_req = 1'b1;
        fetch_pc  = pc;
    endtask

    task automatic ack(input logic [7:0] base);
        ls_ack  = 1'b1;
        ls_data = mk_line(base);
    endtask

    task automatic check_pair(input string tag, input logic [7:0] pc);
        logic [7:0] even;
        even = pc & 8'hFE;
        check_val({tag, "_fv"}, 32'(fetch_valid), 32'h1);
        check_val({tag, "_i0"}, fetch_instr0, 32'h0000_1000 + 32'(even));
        check_val({tag, "_i1"}, fetch_instr1, 32'h0000_1001 + 32'(even));
    endtask

    task automatic check_ls(input string tag, input logic req_exp, input logic [7:0] addr_exp);
        check_val({tag, "_req"}, 32'(ls_req), 32'(req_exp));
        if (req_exp) begin
            check_val({tag, "_addr"}, 32'(ls_addr), 32'(addr_exp));
        end
    endtask

    initial begin
        reset = 1'b0; fetch_req = 1'b0; fetch_pc = 8'h00; redirect = 1'b0;
        redirect_pc = 8'h00; inval = 1'b0; ls_ack = 1'b0; ls_data = '0;
        repeat (3) cyc();
        check_val("rst_fv", 32'(fetch_valid), 32'h0);
        check_val("rst_i0", fetch_instr0, 32'h0);
        check_val("rst_i1", fetch_instr1, 32'h0);
        check_val("rst_req", 32'(ls_req), 32'h0);
        check_val("rst_addr", 32'(ls_addr), 32'h0);
        reset = 1'b1;
        cyc();

        // cold start: miss on line 0, LS answers in the third cycle
        req(8'h00); cyc();
        check_ls("cold_miss", 1'b1, 8'h00);
        check_val("cold_nofv", 32'(fetch_valid), 32'h0);
        cyc(); cyc();
        check_ls("cold_hold", 1'b1, 8'h00);
        ack(8'h00); cyc();
        check_pair("cold", 8'h00);
        check_ls("cold_drop", 1'b0, 8'h00);

        // sequential stream, odd pc 7 treated as 6, prefetch after the pc=8 hit
        req(8'h02); cyc(); check_pair("s02", 8'h02);
        req(8'h04); cyc(); check_pair("s04", 8'h04);
        req(8'h07); cyc(); check_pair("s07", 8'h06);
        req(8'h08); cyc(); check_pair("s08", 8'h08);
        check_ls("pf_issue", 1'b1, 8'h10);
        req(8'h0A); cyc(); check_pair("s0a", 8'h0A);
        req(8'h0C); ack(8'h10); cyc(); check_pair("s0c", 8'h0C);
        check_ls("pf_done", 1'b0, 8'h00);
        req(8'h0E); cyc(); check_pair("s0e", 8'h0E);
        check_ls("no_repf", 1'b0, 8'h00);
        req(8'h10); cyc(); check_pair("s10", 8'h10);

        // wrap prefetch from line 15 to line 0
        req(8'hF0); cyc(); check_ls("f0_miss", 1'b1, 8'hF0);
        ack(8'hF0); cyc(); check_pair("f0", 8'hF0);
        req(8'hF8); cyc(); check_pair("f8", 8'hF8);
        check_ls("wrap_pf", 1'b1, 8'h00);
        fetch_req = 1'b0; ack(8'h00); cyc();
        check_val("pf_nofv", 32'(fetch_valid), 32'h0);
        check_ls("wrap_done", 1'b0, 8'h00);
        req(8'h00); cyc(); check_pair("wrap_hit", 8'h00);

        // inval alone, then pc=0 must refetch
        fetch_req = 1'b0; inval = 1'b1; cyc();
        req(8'h00); cyc();
        check_val("inv_nofv", 32'(fetch_valid), 32'h0);
        check_ls("inv_refetch", 1'b1, 8'h00);
        ack(8'h00); cyc(); check_pair("inv_fill", 8'h00);

        // redirect while a demand miss to 0x40 is outstanding
        req(8'h40); cyc(); check_ls("rd_miss", 1'b1, 8'h40);
        redirect = 1'b1; redirect_pc = 8'h02; fetch_pc = 8'h02; cyc();
        check_val("rd_nofv", 32'(fetch_valid), 32'h0);
        check_ls("rd_hold", 1'b1, 8'h40);
        ack(8'h40); cyc(); check_pair("rd_tgt", 8'h02);
        check_ls("rd_drop", 1'b0, 8'h00);
        req(8'h44); cyc(); check_pair("rd_inst", 8'h44);
        check_ls("rd_inst_ls", 1'b0, 8'h00);

        // demand for the line being prefetched
        req(8'h18); cyc(); check_ls("l1_miss", 1'b1, 8'h10);
        ack(8'h10); cyc(); check_pair("l1", 8'h18);
        req(8'h1A); cyc(); check_pair("l1a", 8'h1A);
        check_ls("pf20", 1'b1, 8'h20);
        req(8'h22); cyc();
        check_val("same_nofv", 32'(fetch_valid), 32'h0);
        check_ls("same_one", 1'b1, 8'h20);
        ack(8'h20); cyc(); check_pair("same", 8'h22);

        // inval suppresses a same-cycle hit
        req(8'h22); inval = 1'b1; cyc();
        check_val("invh_nofv", 32'(fetch_valid), 32'h0);
        check_ls("invh_miss", 1'b1, 8'h20);
        ack(8'h20); cyc(); check_pair("invh", 8'h22);

        // demand for a different line while a prefetch is outstanding
        req(8'h38); cyc(); check_ls("l3_miss", 1'b1, 8'h30);
        ack(8'h30); cyc(); check_pair("l3", 8'h38);
        req(8'h3A); cyc(); check_pair("l3a", 8'h3A);
        check_ls("pf40", 1'b1, 8'h40);
        req(8'h60); cyc();
        check_val("diff_nofv", 32'(fetch_valid), 32'h0);
        check_ls("diff_wait", 1'b1, 8'h40);
        ack(8'h40); cyc();
        check_val("diff_nofv2", 32'(fetch_valid), 32'h0);
        check_ls("diff_issue", 1'b1, 8'h60);
        ack(8'h60); cyc(); check_pair("diff", 8'h60);
        req(8'h42); cyc(); check_pair("pf40_hit", 8'h42);

        // inval together with redirect: the redirect must miss
        fetch_req = 1'b0; redirect = 1'b1; redirect_pc = 8'h42; inval = 1'b1; cyc();
        check_val("ir_nofv", 32'(fetch_valid), 32'h0);
        check_ls("ir_miss", 1'b1, 8'h40);

        // async reset mid-request, then a late ack is ignored
        #3 reset = 1'b0;
        #1;
        check_val("arst_req", 32'(ls_req), 32'h0);
        check_val("arst_fv", 32'(fetch_valid), 32'h0);
        cyc();
        reset = 1'b1;
        ack(8'h40); cyc();
        check_val("late_nofv", 32'(fetch_valid), 32'h0);
        check_val("late_noreq", 32'(ls_req), 32'h0);
        req(8'h42); cyc();
        check_val("late_miss_fv", 32'(fetch_valid), 32'h0);
        check_ls("late_miss", 1'b1, 8'h40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
